// File: rtl/emissor_aposta.sv
// emissor_aposta: collects a five-digit bet from switches and transmits it to
// the game as a train of insert strobes. Each strobe is separated by GAP idle
// cycles, and a finish strobe follows the last digit.
//
// Optional feature: define QUICK_PICK_EN to add the qpick input. qpick fills
// all five slots with pseudo-random digits taken from a free-running 20-bit
// LFSR.
//
// Ports:
//   clk      rising-edge clock
//   reset    asynchronous, active-low reset
//   digit    bet digit from the switches (0..9 accepted)
//   load     store digit into the next free slot
//   send     start transmitting a complete (5-digit) bet
//   clear    abort any transmission and empty all slots
//   qpick    (QUICK_PICK_EN only) fill all slots from the LFSR
//   num      registered digit presented to the game
//   insert   one-cycle strobe marking num valid
//   finish   one-cycle strobe after the fifth digit
//   busy     high while transmitting
//   count    number of loaded slots, 0..5
//   HEX4..0  active-low 7-segment displays; HEX4 = slot0 ... HEX0 = slot4
module emissor_aposta #(
   parameter int unsigned GAP = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] digit,
   input  logic       load,
   input  logic       send,
   input  logic       clear,
`ifdef QUICK_PICK_EN
   input  logic       qpick,
`endif
   output logic [3:0] num,
   output logic       insert,
   output logic       finish,
   output logic       busy,
   output logic [2:0] count,
   output logic [6:0] HEX4,
   output logic [6:0] HEX3,
   output logic [6:0] HEX2,
   output logic [6:0] HEX1,
   output logic [6:0] HEX0
);

   localparam int unsigned SLOTS = 5;
   localparam int unsigned DW    = 4;
   localparam int unsigned CW    = 3;
   localparam int unsigned GW    = 4;
   localparam int unsigned SW    = 7;

   localparam logic [CW-1:0] FULL     = CW'(SLOTS);
   localparam logic [CW-1:0] LAST_IDX = CW'(SLOTS - 1);
   localparam logic [GW-1:0] GAP_INIT = GW'(GAP);
   localparam logic [DW-1:0] MAX_DIG  = DW'(9);
   localparam logic [SW-1:0] DASH     = 7'b0111111;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SEND,
      ST_GAPW,
      ST_FIN,
      ST_DONE
   } state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   count_d;
   logic [CW-1:0]   idx_q, idx_d;
   logic [GW-1:0]   gap_q, gap_d;
   logic [DW-1:0]   slot_q [SLOTS];
   logic [DW-1:0]   slot_d [SLOTS];
   logic [SW-1:0]   hex_d  [SLOTS];

   // Active-low 7-segment encoding of a decimal digit.
   function automatic logic [SW-1:0] seg7(input logic [DW-1:0] d);
      logic [SW-1:0] s;
      case (d)
         4'd0:    s = 7'b1000000;
         4'd1:    s = 7'b1111001;
         4'd2:    s = 7'b0100100;
         4'd3:    s = 7'b0110000;
         4'd4:    s = 7'b0011001;
         4'd5:    s = 7'b0010010;
         4'd6:    s = 7'b0000010;
         4'd7:    s = 7'b1111000;
         4'd8:    s = 7'b0000000;
         4'd9:    s = 7'b0010000;
         default: s = DASH;
      endcase
      return s;
   endfunction

`ifdef QUICK_PICK_EN
   localparam int unsigned LW = 20;
   localparam logic [LW-1:0] LFSR_SEED = 20'h5A5A5;

   logic [LW-1:0] lfsr_q;

   // Fold a raw nibble into a decimal digit.
   function automatic logic [DW-1:0] reduce(input logic [DW-1:0] n);
      return (n >= 4'd10) ? DW'(n - 4'd10) : n;
   endfunction

   // Free-running Fibonacci LFSR, taps 20 and 17.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) lfsr_q <= LFSR_SEED;
      else        lfsr_q <= {lfsr_q[LW-2:0], lfsr_q[19] ^ lfsr_q[16]};
   end
`endif

   // Next-state logic: clear dominates, then per-state behaviour.
   always_comb begin
      state_d = state_q;
      count_d = count;
      idx_d   = idx_q;
      gap_d   = gap_q;
      slot_d  = slot_q;

      if (clear) begin
         state_d = ST_IDLE;
         count_d = '0;
         idx_d   = '0;
         gap_d   = '0;
         for (int i = 0; i < SLOTS; i++) slot_d[i] = '0;
      end else begin
         case (state_q)
            ST_IDLE, ST_DONE: begin
               // send only acts on a full bet, load only on a non-full one,
               // so a simultaneous load+send resolves on count before the edge.
               if (send && count == FULL) begin
                  state_d = ST_SEND;
                  idx_d   = '0;
               end
`ifdef QUICK_PICK_EN
               else if (qpick) begin
                  for (int i = 0; i < SLOTS; i++)
                     slot_d[i] = reduce(lfsr_q[4*i +: 4]);
                  count_d = FULL;
               end
`endif
               else if (load && count < FULL && digit <= MAX_DIG) begin
                  slot_d[count] = digit;
                  count_d       = CW'(count + 3'd1);
               end
            end
            ST_SEND: begin
               state_d = ST_GAPW;
               gap_d   = GAP_INIT;
            end
            ST_GAPW: begin
               if (gap_q <= 4'd1) begin
                  if (idx_q < LAST_IDX) begin
                     state_d = ST_SEND;
                     idx_d   = CW'(idx_q + 3'd1);
                  end else begin
                     state_d = ST_FIN;
                  end
               end else begin
                  gap_d = GW'(gap_q - 4'd1);
               end
            end
            ST_FIN:  state_d = ST_DONE;
            default: state_d = ST_IDLE;
         endcase
      end

      // Display follows the slot contents as they will be after this edge.
      for (int i = 0; i < SLOTS; i++)
         hex_d[i] = (CW'(i) < count_d) ? seg7(slot_d[i]) : DASH;
   end

   // Internal state registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         gap_q   <= '0;
         for (int i = 0; i < SLOTS; i++) slot_q[i] <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         gap_q   <= gap_d;
         for (int i = 0; i < SLOTS; i++) slot_q[i] <= slot_d[i];
      end
   end

   // Registered outputs, decoded from the next state so strobes line up
   // with the cycle the FSM is in.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         num    <= '0;
         insert <= 1'b0;
         finish <= 1'b0;
         busy   <= 1'b0;
         count  <= '0;
         HEX4   <= DASH;
         HEX3   <= DASH;
         HEX2   <= DASH;
         HEX1   <= DASH;
         HEX0   <= DASH;
      end else begin
         insert <= (state_d == ST_SEND);
         finish <= (state_d == ST_FIN);
         busy   <= (state_d == ST_SEND) || (state_d == ST_GAPW) ||
                   (state_d == ST_FIN);
         if (state_d == ST_SEND) num <= slot_d[idx_d];
         count  <= count_d;
         HEX4   <= hex_d[0];
         HEX3   <= hex_d[1];
         HEX2   <= hex_d[2];
         HEX1   <= hex_d[3];
         HEX0   <= hex_d[4];
      end
   end

endmodule

// File: tb/tb_emissor_aposta.sv
// Directed self-checking bench for emissor_aposta (GAP = 4).
module tb_emissor_aposta;

   logic       clk;
   logic       reset;
   logic [3:0] digit;
   logic       load;
   logic       send;
   logic       clear;
`ifdef QUICK_PICK_EN
   logic       qpick;
`endif
   logic [3:0] num;
   logic       insert;
   logic       finish;
   logic       busy;
   logic [2:0] count;
   logic [6:0] HEX4, HEX3, HEX2, HEX1, HEX0;

   int checks;
   int failures;

   logic [3:0] exp_bet [5];
   logic [6:0] hex_act [5];
   logic [6:0] hex_exp [5];

   localparam logic [6:0] DASH = 7'b0111111;

   emissor_aposta #(.GAP(4)) dut (
      .clk    (clk),
      .reset  (reset),
      .digit  (digit),
      .load   (load),
      .send   (send),
      .clear  (clear),
`ifdef QUICK_PICK_EN
      .qpick  (qpick),
`endif
      .num    (num),
      .insert (insert),
      .finish (finish),
      .busy   (busy),
      .count  (count),
      .HEX4   (HEX4),
      .HEX3   (HEX3),
      .HEX2   (HEX2),
      .HEX1   (HEX1),
      .HEX0   (HEX0)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Segment table transcribed from the display code list.
   function automatic logic [6:0] seg_of(input int d);
      case (d)
         0: return 7'b1000000;
         1: return 7'b1111001;
         2: return 7'b0100100;
         3: return 7'b0110000;
         4: return 7'b0011001;
         5: return 7'b0010010;
         6: return 7'b0000010;
         7: return 7'b1111000;
         8: return 7'b0000000;
         9: return 7'b0010000;
         default: return DASH;
      endcase
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      digit = '0; load = 1'b0; send = 1'b0; clear = 1'b0;
`ifdef QUICK_PICK_EN
      qpick = 1'b0;
`endif
      tick();
      tick();
      reset = 1'b1;
   endtask

   task automatic load_digit(input logic [3:0] d);
      digit = d;
      load  = 1'b1;
      tick();
      load  = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      digit = '0; load = 1'b0; send = 1'b0; clear = 1'b0;
`ifdef QUICK_PICK_EN
      qpick = 1'b0;
`endif
      #3;
      reset = 1'b0;
      #1;
      checks++;
      if (insert !== 1'b0 || finish !== 1'b0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL reset_strobes insert=%b finish=%b busy=%b want 000", insert, finish, busy);
      end
      checks++;
      if (count !== 3'd0 || num !== 4'd0) begin
         failures++;
         $display("FAIL reset_count_num count=%0d num=%0d want 0 0", count, num);
      end
      hex_act = '{HEX4, HEX3, HEX2, HEX1, HEX0};
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (hex_act[i] !== DASH) begin
            failures++;
            $display("FAIL reset_hex idx=%0d got=%b want=%b", i, hex_act[i], DASH);
         end
      end
      tick();
      tick();
      reset = 1'b1;
   endtask

   // Load 3,12,4: 12 is rejected; two slots shown; send on a partial bet is ignored.
   task automatic test_load_display();
      do_reset();
      load_digit(4'd3);
      load_digit(4'd12);
      load_digit(4'd4);
      checks++;
      if (count !== 3'd2) begin
         failures++;
         $display("FAIL partial_count got=%0d want=2", count);
      end
      hex_act = '{HEX4, HEX3, HEX2, HEX1, HEX0};
      hex_exp = '{7'b0110000, 7'b0011001, DASH, DASH, DASH};
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (hex_act[i] !== hex_exp[i]) begin
            failures++;
            $display("FAIL partial_hex idx=%0d got=%b want=%b", i, hex_act[i], hex_exp[i]);
         end
      end
      send = 1'b1;
      tick();
      send = 1'b0;
      for (int c = 0; c < 3; c++) begin
         checks++;
         if (busy !== 1'b0 || insert !== 1'b0) begin
            failures++;
            $display("FAIL partial_send_ignored cyc=%0d busy=%b insert=%b want 0 0", c, busy, insert);
         end
         tick();
      end
   endtask

   // Load and send together: count<5 stores the digit, count==5 starts sending.
   task automatic test_simultaneous();
      do_reset();
      load_digit(4'd1);
      load_digit(4'd2);
      load_digit(4'd3);
      load_digit(4'd4);
      digit = 4'd8; load = 1'b1; send = 1'b1;
      tick();
      load = 1'b0; send = 1'b0;
      checks++;
      if (count !== 3'd5 || busy !== 1'b0 || insert !== 1'b0) begin
         failures++;
         $display("FAIL simul_load_wins count=%0d busy=%b insert=%b want 5 0 0", count, busy, insert);
      end
      checks++;
      if (HEX0 !== seg_of(8)) begin
         failures++;
         $display("FAIL simul_hex0 got=%b want=%b", HEX0, seg_of(8));
      end
      digit = 4'd6; load = 1'b1; send = 1'b1;
      tick();
      load = 1'b0; send = 1'b0;
      checks++;
      if (insert !== 1'b1 || num !== 4'd1 || busy !== 1'b1 || count !== 3'd5) begin
         failures++;
         $display("FAIL simul_send_wins insert=%b num=%0d busy=%b count=%0d want 1 1 1 5",
                  insert, num, busy, count);
      end
      clear = 1'b1;
      tick();
      clear = 1'b0;
      checks++;
      if (busy !== 1'b0 || insert !== 1'b0 || count !== 3'd0) begin
         failures++;
         $display("FAIL simul_clear busy=%b insert=%b count=%0d want 0 0 0", busy, insert, count);
      end
   endtask

   // Full 27-cycle transmission window starting at the send edge.
   task automatic run_send(input bit poke_busy);
      send = 1'b1;
      tick();
      send = 1'b0;
      for (int c = 1; c <= 27; c++) begin
         logic exp_ins, exp_fin, exp_busy;
         exp_ins  = (c <= 21) && ((c % 5) == 1);
         exp_fin  = (c == 26);
         exp_busy = (c <= 26);
         checks++;
         if (insert !== exp_ins) begin
            failures++;
            $display("FAIL tx_insert cyc=k+%0d got=%b want=%b", c, insert, exp_ins);
         end
         checks++;
         if (finish !== exp_fin) begin
            failures++;
            $display("FAIL tx_finish cyc=k+%0d got=%b want=%b", c, finish, exp_fin);
         end
         checks++;
         if (busy !== exp_busy) begin
            failures++;
            $display("FAIL tx_busy cyc=k+%0d got=%b want=%b", c, busy, exp_busy);
         end
         if (exp_ins) begin
            checks++;
            if (num !== exp_bet[(c-1)/5]) begin
               failures++;
               $display("FAIL tx_num cyc=k+%0d got=%0d want=%0d", c, num, exp_bet[(c-1)/5]);
            end
         end
         if (c == 26) begin
            checks++;
            if (num !== exp_bet[4]) begin
               failures++;
               $display("FAIL tx_num_hold got=%0d want=%0d", num, exp_bet[4]);
            end
         end
         load = poke_busy && (c == 3);
         digit = 4'd2;
         send = poke_busy && (c == 8);
         tick();
      end
      load = 1'b0;
      send = 1'b0;
      checks++;
      if (count !== 3'd5) begin
         failures++;
         $display("FAIL tx_count_after got=%0d want=5", count);
      end
   endtask

   task automatic test_full_send();
      do_reset();
      exp_bet = '{4'd5, 4'd0, 4'd9, 4'd6, 4'd7};
      for (int i = 0; i < 5; i++) load_digit(exp_bet[i]);
      checks++;
      if (count !== 3'd5) begin
         failures++;
         $display("FAIL full_count got=%0d want=5", count);
      end
      hex_act = '{HEX4, HEX3, HEX2, HEX1, HEX0};
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (hex_act[i] !== seg_of(int'(exp_bet[i]))) begin
            failures++;
            $display("FAIL full_hex idx=%0d got=%b want=%b", i, hex_act[i], seg_of(int'(exp_bet[i])));
         end
      end
      run_send(1'b0);
   endtask

   // Retransmit from DONE; load and send during busy must be ignored.
   task automatic test_back_to_back();
      run_send(1'b1);
      checks++;
      if (HEX0 !== seg_of(7)) begin
         failures++;
         $display("FAIL retx_hex0 got=%b want=%b", HEX0, seg_of(7));
      end
   endtask

   // Clear sampled at edge k+8 aborts after two inserts.
   task automatic test_clear();
      int n_ins;
      int n_fin;
      n_ins = 0;
      n_fin = 0;
      send = 1'b1;
      tick();
      send = 1'b0;
      for (int c = 1; c <= 30; c++) begin
         if (insert === 1'b1) n_ins++;
         if (finish === 1'b1) n_fin++;
         if (c == 9) begin
            checks++;
            if (busy !== 1'b0 || insert !== 1'b0 || finish !== 1'b0 || count !== 3'd0) begin
               failures++;
               $display("FAIL clear_state busy=%b insert=%b finish=%b count=%0d want 0 0 0 0",
                        busy, insert, finish, count);
            end
            hex_act = '{HEX4, HEX3, HEX2, HEX1, HEX0};
            for (int i = 0; i < 5; i++) begin
               checks++;
               if (hex_act[i] !== DASH) begin
                  failures++;
                  $display("FAIL clear_hex idx=%0d got=%b want=%b", i, hex_act[i], DASH);
               end
            end
         end
         clear = (c == 8);
         tick();
      end
      clear = 1'b0;
      checks++;
      if (n_ins != 2 || n_fin != 0) begin
         failures++;
         $display("FAIL clear_strobes inserts=%0d finishes=%0d want 2 0", n_ins, n_fin);
      end
   endtask

   // Asynchronous reset in the middle of a transmission.
   task automatic test_reset_mid();
      int n_str;
      exp_bet = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5};
      for (int i = 0; i < 5; i++) load_digit(exp_bet[i]);
      send = 1'b1;
      tick();
      send = 1'b0;
      for (int c = 1; c < 12; c++) tick();
      #1;
      reset = 1'b0;
      #1;
      checks++;
      if (insert !== 1'b0 || finish !== 1'b0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL rstmid_outputs insert=%b finish=%b busy=%b want 000", insert, finish, busy);
      end
      checks++;
      if (count !== 3'd0 || num !== 4'd0 || HEX4 !== DASH) begin
         failures++;
         $display("FAIL rstmid_state count=%0d num=%0d HEX4=%b want 0 0 %b", count, num, HEX4, DASH);
      end
      tick();
      reset = 1'b1;
      n_str = 0;
      for (int c = 0; c < 30; c++) begin
         tick();
         if (insert === 1'b1 || finish === 1'b1 || busy === 1'b1) n_str++;
      end
      checks++;
      if (n_str != 0) begin
         failures++;
         $display("FAIL rstmid_after active_cycles=%0d want 0", n_str);
      end
   endtask

`ifdef QUICK_PICK_EN
   // qpick in the first cycle after reset loads the reduced seed nibbles.
   task automatic test_qpick();
      do_reset();
      qpick = 1'b1;
      tick();
      qpick = 1'b0;
      checks++;
      if (count !== 3'd5) begin
         failures++;
         $display("FAIL qpick_count got=%0d want=5", count);
      end
      hex_act = '{HEX4, HEX3, HEX2, HEX1, HEX0};
      hex_exp = '{seg_of(5), seg_of(0), seg_of(5), seg_of(0), seg_of(5)};
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (hex_act[i] !== hex_exp[i]) begin
            failures++;
            $display("FAIL qpick_hex idx=%0d got=%b want=%b", i, hex_act[i], hex_exp[i]);
         end
      end
   endtask
`endif

   initial begin
      checks   = 0;
      failures = 0;
      test_reset();
      test_load_display();
      test_simultaneous();
      test_full_send();
      test_back_to_back();
      test_clear();
      test_reset_mid();
`ifdef QUICK_PICK_EN
      test_qpick();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
